// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type for the
// bus decoder/mux slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave for unmapped space: two-cycle ERROR response per active
// transfer, plus a saturating count of ERROR responses issued.
module ahblite_default_slave
  import ahb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             hreadyout,
  output logic             hresp,
  output logic [CNT_W-1:0] err_cnt
);

  ds_state_e state, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DS_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    case (state)
      DS_IDLE: begin
        if (start) state_next = DS_ERR1;
      end
      DS_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = HRESP_ERROR;
        state_next = DS_ERR2;
      end
      DS_ERR2: begin
        hresp      = HRESP_ERROR;
        state_next = start ? DS_ERR1 : DS_IDLE;
      end
      default: state_next = DS_IDLE;
    endcase
  end

  // ERR1 can never follow ERR1, so next==ERR1 marks exactly one entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (state_next == DS_ERR1 && err_cnt != {CNT_W{1'b1}})
      err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/ahblite_bus_decoder_mux.sv
// AHB-Lite slave-side interconnect: address decode into windows, registered
// data-phase select, response mux and a built-in default slave.
module ahblite_bus_decoder_mux
  import ahb_pkg::*;
#(
  parameter int                      NUM_PORTS = 4,
  parameter logic [NUM_PORTS-1:0]    PORT_EN   = 4'b1111,
  parameter logic [32*NUM_PORTS-1:0] PORT_BASE =
    {32'h40000010, 32'h40000000, 32'h20000000, 32'h00000000},
  parameter logic [32*NUM_PORTS-1:0] PORT_MASK =
    {32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF0000},
  parameter int                      CNT_W     = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HREADY,
  output logic [NUM_PORTS-1:0]      HSEL_S,
  input  logic [32*NUM_PORTS-1:0]   HRDATA_S,
  input  logic [NUM_PORTS-1:0]      HREADYOUT_S,
  input  logic [NUM_PORTS-1:0]      HRESP_S,
  output logic [31:0]               HRDATA,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [CNT_W-1:0]          ERR_CNT
);

  localparam logic [NUM_PORTS:0] SEL_DEFAULT = {1'b1, {NUM_PORTS{1'b0}}};

  logic [NUM_PORTS-1:0] hit;
  logic                 hit_any;
  logic                 active;
  logic                 ds_start;
  logic                 ds_ready;
  logic                 ds_resp;
  logic [NUM_PORTS:0]   sel_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_hit
    assign hit[i] = PORT_EN[i] &
                    ((HADDR & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32]);
  end

  // Lowest-index hit wins when windows overlap.
  always_comb begin
    HSEL_S  = '0;
    hit_any = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (hit[i] && !hit_any) begin
        HSEL_S[i] = 1'b1;
        hit_any   = 1'b1;
      end
    end
  end

  assign active   = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign ds_start = HREADY && !hit_any && active;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      sel_q <= SEL_DEFAULT;
    else if (HREADY)
      sel_q <= hit_any ? {1'b0, HSEL_S} : SEL_DEFAULT;
  end

  ahblite_default_slave #(
    .CNT_W(CNT_W)
  ) u_default_slave (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .start    (ds_start),
    .hreadyout(ds_ready),
    .hresp    (ds_resp),
    .err_cnt  (ERR_CNT)
  );

  // Response path follows the registered data-phase select only.
  always_comb begin
    HRDATA    = '0;
    HREADYOUT = ds_ready;
    HRESP     = ds_resp;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_q[i]) begin
        HRDATA    = HRDATA_S[32*i +: 32];
        HREADYOUT = HREADYOUT_S[i];
        HRESP     = HRESP_S[i];
      end
    end
  end

endmodule

// File: tb/tb_ahblite_bus_decoder_mux.sv
// Directed self-checking bench for ahblite_bus_decoder_mux: decode, wait
// states, default-slave ERROR sequencing, counter saturation, port enable, reset.
module tb_ahblite_bus_decoder_mux;

  logic         clk;
  logic         rst_n;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hready;
  logic [3:0]   hsel_s;
  logic [127:0] hrdata_s;
  logic [3:0]   hreadyout_s;
  logic [3:0]   hresp_s;
  logic [31:0]  hrdata;
  logic         hreadyout;
  logic         hresp;
  logic [7:0]   err_cnt;

  logic [31:0]  haddr2;
  logic [1:0]   htrans2;
  logic         hready2;
  logic [3:0]   hsel_s2;
  logic [31:0]  hrdata2;
  logic         hreadyout2;
  logic         hresp2;
  logic [7:0]   err_cnt2;

  int assert_count = 0;
  int fail_count   = 0;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  assign hready  = hreadyout;
  assign hready2 = hreadyout2;

  ahblite_bus_decoder_mux u_dut (
    .HCLK       (clk),
    .HRESETn    (rst_n),
    .HADDR      (haddr),
    .HTRANS     (htrans),
    .HREADY     (hready),
    .HSEL_S     (hsel_s),
    .HRDATA_S   (hrdata_s),
    .HREADYOUT_S(hreadyout_s),
    .HRESP_S    (hresp_s),
    .HRDATA     (hrdata),
    .HREADYOUT  (hreadyout),
    .HRESP      (hresp),
    .ERR_CNT    (err_cnt)
  );

  // Second instance with port 0 disabled.
  ahblite_bus_decoder_mux #(
    .PORT_EN(4'b1110)
  ) u_dut_en (
    .HCLK       (clk),
    .HRESETn    (rst_n),
    .HADDR      (haddr2),
    .HTRANS     (htrans2),
    .HREADY     (hready2),
    .HSEL_S     (hsel_s2),
    .HRDATA_S   (hrdata_s),
    .HREADYOUT_S(hreadyout_s),
    .HRESP_S    (hresp_s),
    .HRDATA     (hrdata2),
    .HREADYOUT  (hreadyout2),
    .HRESP      (hresp2),
    .ERR_CNT    (err_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans);
    haddr  = addr;
    htrans = trans;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    haddr       = 32'h0;
    htrans      = T_IDLE;
    haddr2      = 32'h0;
    htrans2     = T_IDLE;
    hrdata_s    = '0;
    hrdata_s[31:0]   = 32'hCAFE0000;
    hrdata_s[63:32]  = 32'h11112222;
    hrdata_s[127:96] = 32'h33333333;
    hreadyout_s = 4'b1111;
    hresp_s     = 4'b0000;

    // Reset state
    #12;
    checkOutput("rst_hrdata", hrdata, 32'h0);
    checkOutput("rst_hreadyout", {31'b0, hreadyout}, 32'h1);
    checkOutput("rst_hresp", {31'b0, hresp}, 32'h0);
    checkOutput("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
    rst_n = 1'b1;
    step();

    // Test 1: slave 0 read
    applyStimulus(32'h00000100, T_NONSEQ);
    checkOutput("t1_hsel", {28'b0, hsel_s}, 32'h1);
    step();
    applyStimulus(32'h00000100, T_IDLE);
    checkOutput("t1_hrdata", hrdata, 32'hCAFE0000);
    checkOutput("t1_hresp", {31'b0, hresp}, 32'h0);

    // Test 2: slave 3 with three wait states
    hreadyout_s[3] = 1'b0;
    applyStimulus(32'h40000014, T_NONSEQ);
    checkOutput("t2_hsel", {28'b0, hsel_s}, 32'h8);
    step();
    applyStimulus(32'h00000100, T_NONSEQ);
    checkOutput("t2_hsel_live", {28'b0, hsel_s}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t2_wait%0d", i), {31'b0, hreadyout}, 32'h0);
      if (i < 2) step();
    end
    hreadyout_s[3] = 1'b1;
    #1;
    checkOutput("t2_ready", {31'b0, hreadyout}, 32'h1);
    checkOutput("t2_hrdata_held", hrdata, 32'h33333333);
    step();
    applyStimulus(32'h00000100, T_IDLE);
    checkOutput("t2_next_hrdata", hrdata, 32'hCAFE0000);
    checkOutput("t2_err_cnt", {24'b0, err_cnt}, 32'h0);

    // Slave 1 with an ERROR of its own passes through
    hresp_s[1] = 1'b1;
    applyStimulus(32'h20001234, T_NONSEQ);
    checkOutput("s1_hsel", {28'b0, hsel_s}, 32'h2);
    step();
    applyStimulus(32'h20001234, T_IDLE);
    checkOutput("s1_hrdata", hrdata, 32'h11112222);
    checkOutput("s1_hresp", {31'b0, hresp}, 32'h1);
    hresp_s[1] = 1'b0;

    // Test 3: unmapped access
    applyStimulus(32'h30000000, T_NONSEQ);
    checkOutput("t3_hsel", {28'b0, hsel_s}, 32'h0);
    step();
    applyStimulus(32'h30000000, T_IDLE);
    checkOutput("t3_err1_ready", {31'b0, hreadyout}, 32'h0);
    checkOutput("t3_err1_resp", {31'b0, hresp}, 32'h1);
    checkOutput("t3_err1_hrdata", hrdata, 32'h0);
    checkOutput("t3_err_cnt", {24'b0, err_cnt}, 32'h1);
    step();
    checkOutput("t3_err2_ready", {31'b0, hreadyout}, 32'h1);
    checkOutput("t3_err2_resp", {31'b0, hresp}, 32'h1);
    step();
    checkOutput("t3_idle_ready", {31'b0, hreadyout}, 32'h1);
    checkOutput("t3_idle_resp", {31'b0, hresp}, 32'h0);

    // Test 4: back-to-back errors, then IDLE/BUSY to unmapped space
    applyStimulus(32'h30000000, T_NONSEQ);
    step();
    checkOutput("t4_a_err1_ready", {31'b0, hreadyout}, 32'h0);
    checkOutput("t4_a_err_cnt", {24'b0, err_cnt}, 32'h2);
    applyStimulus(32'h50000000, T_NONSEQ);
    step();
    checkOutput("t4_a_err2_ready", {31'b0, hreadyout}, 32'h1);
    checkOutput("t4_a_err2_resp", {31'b0, hresp}, 32'h1);
    step();
    checkOutput("t4_b_err1_ready", {31'b0, hreadyout}, 32'h0);
    checkOutput("t4_b_err1_resp", {31'b0, hresp}, 32'h1);
    checkOutput("t4_b_err_cnt", {24'b0, err_cnt}, 32'h3);
    applyStimulus(32'h50000000, T_IDLE);
    step();
    checkOutput("t4_b_err2_resp", {31'b0, hresp}, 32'h1);
    step();
    applyStimulus(32'h30000000, T_IDLE);
    step();
    checkOutput("t4_idle_resp", {31'b0, hresp}, 32'h0);
    checkOutput("t4_idle_ready", {31'b0, hreadyout}, 32'h1);
    applyStimulus(32'h30000000, T_BUSY);
    step();
    checkOutput("t4_busy_resp", {31'b0, hresp}, 32'h0);
    checkOutput("t4_busy_err_cnt", {24'b0, err_cnt}, 32'h3);

    // Test 5: counter saturation (3 + 260 entries)
    applyStimulus(32'h30000000, T_NONSEQ);
    repeat (500) step();
    checkOutput("t5_cnt_253", {24'b0, err_cnt}, 32'd253);
    repeat (20) step();
    checkOutput("t5_cnt_sat", {24'b0, err_cnt}, 32'd255);
    checkOutput("t5_err2_resp", {31'b0, hresp}, 32'h1);
    applyStimulus(32'h30000000, T_IDLE);
    step();
    checkOutput("t5_idle_resp", {31'b0, hresp}, 32'h0);
    checkOutput("t5_cnt_hold", {24'b0, err_cnt}, 32'd255);

    // Port 0 disabled: address 0 goes to the default slave
    haddr2  = 32'h20000000;
    htrans2 = T_IDLE;
    #1;
    checkOutput("en_hsel_port1", {28'b0, hsel_s2}, 32'h2);
    haddr2  = 32'h00000000;
    htrans2 = T_NONSEQ;
    #1;
    checkOutput("en_hsel_none", {28'b0, hsel_s2}, 32'h0);
    step();
    htrans2 = T_IDLE;
    #1;
    checkOutput("en_err1_ready", {31'b0, hreadyout2}, 32'h0);
    checkOutput("en_err1_resp", {31'b0, hresp2}, 32'h1);
    checkOutput("en_err_cnt", {24'b0, err_cnt2}, 32'h1);
    step();
    step();

    // Test 6: reset asserted during ERR1
    applyStimulus(32'h30000000, T_NONSEQ);
    step();
    checkOutput("t6_err1_ready", {31'b0, hreadyout}, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_ready", {31'b0, hreadyout}, 32'h1);
    checkOutput("t6_rst_resp", {31'b0, hresp}, 32'h0);
    checkOutput("t6_rst_hrdata", hrdata, 32'h0);
    checkOutput("t6_rst_err_cnt", {24'b0, err_cnt}, 32'h0);
    applyStimulus(32'h30000000, T_IDLE);
    rst_n = 1'b1;
    step();
    checkOutput("t6_after_cnt", {24'b0, err_cnt}, 32'h0);
    checkOutput("t6_after_resp", {31'b0, hresp}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
